// File: rtl/sqrt_operand_queue_if.sv
// ---------------------------------------------------------------------------
// sqrt_operand_queue_if
// Purpose : Bundles the operand push side and the sqrt-core issue side of the
//           square-root operand queue into one interface.
// Signals : start/in_mantisa/in_exp/in_flags/in_type/sign -> operand push
//           in_ready                                       <- queue not full
//           ready                                          -> sqrt core idle
//           start_sqrt/bypass_valid/out_*                  <- issued entry
// Modports: master = operand producer + sqrt core side, slave = the queue.
// ---------------------------------------------------------------------------
interface sqrt_operand_queue_if #(
    parameter int IN_M_SIZE  = 53,
    parameter int OUT_M_SIZE = 106,
    parameter int EXP_SIZE   = 11
);
    logic                  start;
    logic [IN_M_SIZE-1:0]  in_mantisa;
    logic [EXP_SIZE-1:0]   in_exp;
    logic [2:0]            in_flags;
    logic                  in_type;
    logic                  sign;
    logic                  in_ready;
    logic                  ready;
    logic                  start_sqrt;
    logic                  bypass_valid;
    logic [OUT_M_SIZE-1:0] out_mantisa;
    logic [EXP_SIZE-1:0]   out_exp;
    logic [2:0]            out_flags;
    logic                  out_type;
    logic                  out_sign;

    modport master (
        output start, in_mantisa, in_exp, in_flags, in_type, sign, ready,
        input  in_ready, start_sqrt, bypass_valid, out_mantisa, out_exp,
               out_flags, out_type, out_sign
    );

    modport slave (
        input  start, in_mantisa, in_exp, in_flags, in_type, sign, ready,
        output in_ready, start_sqrt, bypass_valid, out_mantisa, out_exp,
               out_flags, out_type, out_sign
    );
endinterface

// File: rtl/sqrt_operand_queue.sv
// ---------------------------------------------------------------------------
// sqrt_operand_queue
// Purpose : Operand front end of the FPU square-root core. Each pushed operand
//           is aligned to an even exponent, widened to OUT_M_SIZE, classified
//           (normal vs. special/bypass) and stored in a DEPTH-entry FIFO. A
//           small FSM issues entries in order to the core under ready/start.
// Ports   : clk   - rising-edge clock
//           rst   - asynchronous active-low reset
//           bus   - sqrt_operand_queue_if.slave (push side + issue side)
//           ovf   - sticky "push while full" flag (only with SQRT_Q_OVF_EN)
// Config  : define SQRT_Q_OVF_EN to add the sticky ovf output.
// ---------------------------------------------------------------------------
module sqrt_operand_queue #(
    parameter int IN_M_SIZE  = 53,
    parameter int OUT_M_SIZE = 106,
    parameter int EXP_SIZE   = 11,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sqrt_operand_queue_if.slave     bus
`ifdef SQRT_Q_OVF_EN
    ,
    output logic                    ovf
`endif
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int PAD = OUT_M_SIZE - IN_M_SIZE;
    localparam logic signed [EXP_SIZE+1:0] BIAS_S = (EXP_SIZE+2)'((2 ** (EXP_SIZE - 1)) - 1);

    typedef struct packed {
        logic [OUT_M_SIZE-1:0] mant;
        logic [EXP_SIZE-1:0]   exp;
        logic [2:0]            flags;
        logic                  typ;
        logic                  sgn;
        logic                  byp;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;

    // ---------------- operand preparation ----------------
    logic signed [EXP_SIZE+1:0] w_e;
    logic signed [EXP_SIZE+1:0] w_eh;
    logic [EXP_SIZE-1:0]        w_oexp;
    logic [OUT_M_SIZE-1:0]      w_mant_w;
    logic [OUT_M_SIZE-1:0]      w_mant;
    entry_t                     w_entry;

    // Unbiased exponent, then arithmetic halving (floor) and re-bias.
    assign w_e    = $signed({2'b00, bus.in_exp}) - BIAS_S;
    assign w_eh   = w_e >>> 1;
    assign w_oexp = EXP_SIZE'(w_eh + BIAS_S);

    // Odd biased exponent means even unbiased exponent: the radicand gets an
    // extra leading zero so it sits in [1,2); otherwise it stays in [1,4).
    assign w_mant_w = {bus.in_mantisa, {PAD{1'b0}}};
    assign w_mant   = bus.in_exp[0] ? (w_mant_w >> 1) : w_mant_w;

    always_comb begin
        w_entry       = '0;
        w_entry.mant  = w_mant;
        w_entry.exp   = w_oexp;
        w_entry.typ   = bus.in_type;
        w_entry.sgn   = bus.sign;
        w_entry.byp   = 1'b1;
        if (bus.in_flags[0]) begin
            w_entry.flags = 3'b001;                       // nan
        end else if (bus.sign && (bus.in_flags[2] || bus.in_flags[1])) begin
            w_entry.flags = 3'b001;                       // sqrt of negative
            w_entry.sgn   = 1'b0;
        end else if (bus.in_flags[1]) begin
            w_entry.flags = 3'b010;                       // +inf
        end else if (!bus.in_flags[2]) begin
            w_entry.flags = 3'b000;                       // signed zero kept
        end else begin
            w_entry.flags = 3'b100;
            w_entry.byp   = 1'b0;
        end
    end

    // ---------------- FIFO ----------------
    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_in_ready;
    logic          w_push;
    logic          w_pop;
    state_t        r_state;

    assign w_push      = bus.start && r_in_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && bus.ready;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_entry;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != CW'(DEPTH));
        end
    end

    // ---------------- issue FSM ----------------
    logic                  r_start_sqrt;
    logic                  r_bypass_valid;
    logic [OUT_M_SIZE-1:0] r_out_mantisa;
    logic [EXP_SIZE-1:0]   r_out_exp;
    logic [2:0]            r_out_flags;
    logic                  r_out_type;
    logic                  r_out_sign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_start_sqrt   <= 1'b0;
            r_bypass_valid <= 1'b0;
            r_out_mantisa  <= '0;
            r_out_exp      <= '0;
            r_out_flags    <= '0;
            r_out_type     <= 1'b0;
            r_out_sign     <= 1'b0;
        end else begin
            r_start_sqrt   <= 1'b0;
            r_bypass_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_out_mantisa  <= r_mem[r_rptr].mant;
                        r_out_exp      <= r_mem[r_rptr].exp;
                        r_out_flags    <= r_mem[r_rptr].flags;
                        r_out_type     <= r_mem[r_rptr].typ;
                        r_out_sign     <= r_mem[r_rptr].sgn;
                        r_start_sqrt   <= !r_mem[r_rptr].byp;
                        r_bypass_valid <= r_mem[r_rptr].byp;
                        r_state        <= S_ISSUE;
                    end
                end
                // The pulse registered at pop tells which path this entry takes.
                S_ISSUE: r_state <= r_bypass_valid ? S_IDLE : S_HOLD;
                // Core drops ready one cycle after start; do not look at it here.
                S_HOLD:  r_state <= S_WAIT;
                S_WAIT:  if (bus.ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.start_sqrt   = r_start_sqrt;
    assign bus.bypass_valid = r_bypass_valid;
    assign bus.out_mantisa  = r_out_mantisa;
    assign bus.out_exp      = r_out_exp;
    assign bus.out_flags    = r_out_flags;
    assign bus.out_type     = r_out_type;
    assign bus.out_sign     = r_out_sign;

`ifdef SQRT_Q_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          r_ovf <= 1'b0;
        else if (bus.start && !r_in_ready) r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_sqrt_operand_queue.sv
module tb_sqrt_operand_queue;
    localparam int IM = 53;
    localparam int OM = 106;
    localparam int EW = 11;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sqrt_operand_queue_if #(.IN_M_SIZE(IM), .OUT_M_SIZE(OM), .EXP_SIZE(EW)) bus ();
`ifdef SQRT_Q_OVF_EN
    logic ovf;
`endif

    sqrt_operand_queue #(.IN_M_SIZE(IM), .OUT_M_SIZE(OM), .EXP_SIZE(EW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SQRT_Q_OVF_EN
        ,
        .ovf (ovf)
`endif
    );

    typedef struct {
        logic [OM-1:0] m;
        logic [EW-1:0] e;
        logic [2:0]    f;
        logic          s;
        logic          t;
        logic          byp;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_start = -1;
    int   pulse_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Reference model written from the arithmetic definition.
    function automatic exp_t model(input logic [IM-1:0] m, input logic [EW-1:0] e,
                                   input logic [2:0] f, input logic s, input logic t);
        exp_t r;
        int ue, he;
        ue = int'(e) - 1023;
        he = (ue >= 0) ? ue / 2 : -((1 - ue) / 2);
        r.e = EW'(1023 + he);
        if (e[0]) r.m = {1'b0, m, 52'b0};
        else      r.m = {m, 53'b0};
        r.t = t;
        r.s = s;
        r.byp = 1'b1;
        if (f[0])                  r.f = 3'b001;
        else if (s && (f[2] || f[1])) begin r.f = 3'b001; r.s = 1'b0; end
        else if (f[1])             r.f = 3'b010;
        else if (!f[2])            r.f = 3'b000;
        else begin r.f = 3'b100; r.byp = 1'b0; end
        return r;
    endfunction

    // Scoreboard monitor: compares every issue pulse with the oldest expected entry.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            last_start = -1;
        end else if (bus.start_sqrt || bus.bypass_valid) begin
            exp_t x;
            pulse_cnt++;
            chk("pulse_excl", 128'(bus.start_sqrt & bus.bypass_valid), 128'(0));
            chk("sb_nonempty", 128'(sbq.size() != 0), 128'(1));
            if (sbq.size() != 0) begin
                x = sbq.pop_front();
                chk("start_vs_byp", 128'(bus.start_sqrt), 128'(!x.byp));
                chk("out_mantisa",  128'(bus.out_mantisa), 128'(x.m));
                chk("out_flags",    128'(bus.out_flags), 128'(x.f));
                chk("out_sign",     128'(bus.out_sign), 128'(x.s));
                chk("out_type",     128'(bus.out_type), 128'(x.t));
                if (!x.byp) chk("out_exp", 128'(bus.out_exp), 128'(x.e));
            end
            if (bus.start_sqrt) begin
                if (last_start >= 0) chk("start_gap_ge3", 128'((cyc - last_start) >= 3), 128'(1));
                last_start = cyc;
            end
        end
    end

    task automatic push(input logic [IM-1:0] m, input logic [EW-1:0] e,
                        input logic [2:0] f, input logic s, input logic t);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_wait", 128'(bus.in_ready), 128'(1));
        bus.in_mantisa = m; bus.in_exp = e; bus.in_flags = f; bus.sign = s; bus.in_type = t;
        bus.start = 1'b1;
        if (bus.in_ready) sbq.push_back(model(m, e, f, s, t));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(sbq.size()), 128'(0));
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [IM-1:0] rmant();
        return {1'b1, 20'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [IM-1:0] m1;
        logic [2:0]    fl [5];
        int p0, n;
        fl[0] = 3'b100; fl[1] = 3'b000; fl[2] = 3'b010; fl[3] = 3'b001; fl[4] = 3'b100;
        m1 = 53'h10000000000000;
        bus.start = 0; bus.in_mantisa = '0; bus.in_exp = '0; bus.in_flags = '0;
        bus.in_type = 0; bus.sign = 0; bus.ready = 1;

        // start during reset must be ignored
        @(negedge clk);
        bus.in_mantisa = m1; bus.in_exp = 11'h3FF; bus.in_flags = 3'b100; bus.start = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("rst_in_ready",  128'(bus.in_ready), 128'(1));
        chk("rst_start",     128'(bus.start_sqrt), 128'(0));
        chk("rst_bypass",    128'(bus.bypass_valid), 128'(0));
        chk("rst_mant",      128'(bus.out_mantisa), 128'(0));
        chk("rst_exp",       128'(bus.out_exp), 128'(0));
        chk("rst_flags",     128'(bus.out_flags), 128'(0));
        chk("rst_sign",      128'(bus.out_sign), 128'(0));
`ifdef SQRT_Q_OVF_EN
        chk("rst_ovf",       128'(ovf), 128'(0));
`endif
        @(negedge clk) rst = 1'b1;
        p0 = pulse_cnt;
        repeat (4) @(negedge clk);
        chk("no_pulse_after_rst_start", 128'(pulse_cnt - p0), 128'(0));

        // even e, latency: pulse on second falling edge after the push edge
        push(m1, 11'h3FF, 3'b100, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_n1", 128'(bus.start_sqrt), 128'(0));
        @(negedge clk);
        chk("lat_n2", 128'(bus.start_sqrt), 128'(1));
        drain();

        // odd e
        push(m1, 11'h400, 3'b100, 1'b0, 1'b1);
        push(rmant(), 11'h3FE, 3'b100, 1'b0, 1'b0);
        push(rmant(), 11'h001, 3'b100, 1'b0, 1'b1);
        push(rmant(), 11'h7FE, 3'b100, 1'b0, 1'b0);
        drain();

        // specials
        push(rmant(), 11'h3FF, 3'b100, 1'b1, 1'b0);
        push('0, 11'h000, 3'b000, 1'b1, 1'b1);
        push('0, 11'h7FF, 3'b010, 1'b0, 1'b0);
        push('0, 11'h7FF, 3'b010, 1'b1, 1'b0);
        push(rmant(), 11'h7FF, 3'b001, 1'b1, 1'b1);
        drain();

        // mixed random order
        for (int i = 0; i < 12; i++)
            push(rmant(), 11'($urandom), fl[$urandom_range(0, 4)], 1'($urandom), 1'($urandom));
        drain();

        // full FIFO with core busy
        bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [IM-1:0] m;
            @(negedge clk);
            chk("full_in_ready", 128'(bus.in_ready), 128'(i < DP));
`ifdef SQRT_Q_OVF_EN
            chk("ovf_pre", 128'(ovf), 128'(0));
`endif
            m = rmant();
            bus.in_mantisa = m; bus.in_exp = 11'(12'h3F0 + i); bus.in_flags = 3'b100;
            bus.sign = 1'b0; bus.in_type = 1'b0; bus.start = 1'b1;
            if (i < DP) sbq.push_back(model(m, 11'(12'h3F0 + i), 3'b100, 1'b0, 1'b0));
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        @(negedge clk);
        chk("full_in_ready_after", 128'(bus.in_ready), 128'(0));
`ifdef SQRT_Q_OVF_EN
        chk("ovf_set", 128'(ovf), 128'(1));
`endif
        p0 = pulse_cnt;
        bus.ready = 1'b1;
        drain();
        chk("full_pulses", 128'(pulse_cnt - p0), 128'(DP));

        // reset while in HOLD with two entries queued
        bus.ready = 1'b0;
        push(rmant(), 11'h3FF, 3'b100, 1'b0, 1'b0);
        push(rmant(), 11'h401, 3'b100, 1'b0, 1'b0);
        push(rmant(), 11'h402, 3'b100, 1'b0, 1'b0);
        @(negedge clk);
        bus.ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.start_sqrt && n < 20);
        chk("midop_pulse_seen", 128'(bus.start_sqrt), 128'(1));
        @(negedge clk);
        #2 rst = 1'b0;
        sbq.delete();
        #1;
        chk("midop_in_ready", 128'(bus.in_ready), 128'(1));
        chk("midop_start",    128'(bus.start_sqrt), 128'(0));
        chk("midop_mant",     128'(bus.out_mantisa), 128'(0));
        chk("midop_exp",      128'(bus.out_exp), 128'(0));
        chk("midop_flags",    128'(bus.out_flags), 128'(0));
`ifdef SQRT_Q_OVF_EN
        chk("midop_ovf",      128'(ovf), 128'(0));
`endif
        @(negedge clk);
        #2 rst = 1'b1;
        p0 = pulse_cnt;
        repeat (10) @(negedge clk);
        chk("midop_no_pulse", 128'(pulse_cnt - p0), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
